// File: rtl/engine_model_if.sv
// Signal bundle between the race controller and the engine model.
// Handshake: no valid/ready; tick is a single-cycle strobe qualifying physics
// updates, while rpm/speed/limiter/shift_event are registered and always valid.
interface engine_model_if;
  logic        reset_status;
  logic        tick;
  logic        throttle;
  logic [1:0]  gear;
  logic [13:0] rpm;
  logic [9:0]  speed;
  logic        limiter;
  logic        shift_event;
  logic        state_dbg;

  modport master (
    output reset_status, tick, throttle, gear,
    input  rpm, speed, limiter, shift_event, state_dbg
  );

  modport slave (
    input  reset_status, tick, throttle, gear,
    output rpm, speed, limiter, shift_event, state_dbg
  );
endinterface

// File: rtl/engine_model.sv
// Engine rpm / vehicle speed model with gear-shift detection and rev limiter.
// Optional rev limiter (LIMIT state) is enabled by defining ENGINE_LIMITER_EN.
module engine_model #(
  parameter int RPM_IDLE    = 1000,
  parameter int RPM_MAX     = 8000,
  parameter int SHIFT_DROP  = 3000,
  parameter int DECEL       = 150,
  parameter int LIMIT_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  engine_model_if.slave bus
);
  localparam int CW = (LIMIT_TICKS < 2) ? 1 : $clog2(LIMIT_TICKS + 1);
  localparam logic [13:0] IDLE14  = 14'(RPM_IDLE);
  localparam logic [13:0] MAX14   = 14'(RPM_MAX);
  localparam logic [13:0] DROP14  = 14'(SHIFT_DROP);
  localparam logic [13:0] DECEL14 = 14'(DECEL);
`ifdef ENGINE_LIMITER_EN
  localparam logic [CW-1:0] LT = CW'(LIMIT_TICKS);
`endif

  typedef enum logic {RUN = 1'b0, LIMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [13:0] rpm_q, rpm_d;
  logic [9:0]  speed_q, speed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  gear_q;
  logic        shift_q;
  logic        shift, upshift;
  logic [8:0]  accel;
  logic [4:0]  kfac;
  logic [18:0] prod;
  logic [10:0] target;
  logic [14:0] sum;

  // Subtract with the idle rpm as the floor.
  function automatic logic [13:0] sub_floor(input logic [13:0] r, input logic [13:0] amt);
    if ({1'b0, r} >= ({1'b0, IDLE14} + {1'b0, amt})) return r - amt;
    else return IDLE14;
  endfunction

  always_comb begin
    shift   = (bus.gear != gear_q);
    upshift = (bus.gear > gear_q);
    unique case (bus.gear)
      2'd0: begin accel = 9'd400; kfac = 5'd8;  end
      2'd1: begin accel = 9'd300; kfac = 5'd12; end
      2'd2: begin accel = 9'd200; kfac = 5'd17; end
      default: begin accel = 9'd120; kfac = 5'd22; end
    endcase
    prod   = 19'(rpm_q) * 19'(kfac);
    target = 11'(prod >> 8);
    sum    = {1'b0, rpm_q} + {6'b0, accel};

    state_d = state_q;
    rpm_d   = rpm_q;
    speed_d = speed_q;
    cnt_d   = cnt_q;

    if (bus.tick) begin
      if (({1'b0, speed_q} < target) && (speed_q != 10'h3FF)) speed_d = speed_q + 10'd1;
      else if (({1'b0, speed_q} > target) && (speed_q != 10'd0)) speed_d = speed_q - 10'd1;
    end

    // A gear change wins over the tick's rpm update; speed still moves above.
    if (shift) begin
      if (upshift) begin
        rpm_d   = sub_floor(rpm_q, DROP14);
        state_d = RUN;
      end else begin
        rpm_d = MAX14;
`ifdef ENGINE_LIMITER_EN
        state_d = LIMIT;
        cnt_d   = LT;
`endif
      end
    end else if (bus.tick) begin
      case (state_q)
        LIMIT: begin
`ifdef ENGINE_LIMITER_EN
          rpm_d = sub_floor(rpm_q, 14'd500);
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
`else
          state_d = RUN;
`endif
        end
        default: begin
          if (bus.throttle) begin
            if (sum >= {1'b0, MAX14}) begin
              rpm_d = MAX14;
`ifdef ENGINE_LIMITER_EN
              state_d = LIMIT;
              cnt_d   = LT;
`endif
            end else begin
              rpm_d = sum[13:0];
            end
          end else begin
            rpm_d = sub_floor(rpm_q, DECEL14);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      rpm_q   <= IDLE14;
      speed_q <= '0;
      cnt_q   <= '0;
      gear_q  <= '0;
      shift_q <= 1'b0;
    end else if (bus.reset_status) begin
      state_q <= RUN;
      rpm_q   <= IDLE14;
      speed_q <= '0;
      cnt_q   <= '0;
      gear_q  <= bus.gear;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rpm_q   <= rpm_d;
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      gear_q  <= bus.gear;
      shift_q <= shift;
    end
  end

  assign bus.rpm         = rpm_q;
  assign bus.speed       = speed_q;
  assign bus.shift_event = shift_q;
  assign bus.state_dbg   = logic'(state_q);
`ifdef ENGINE_LIMITER_EN
  assign bus.limiter = (state_q == LIMIT);
`else
  assign bus.limiter = 1'b0;
`endif
endmodule

// File: tb/tb_engine_model.sv
// Directed scoreboard bench for engine_model; expectations adapt to ENGINE_LIMITER_EN.
module tb_engine_model;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  engine_model_if bus();
  engine_model dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ENGINE_LIMITER_EN
  localparam logic LIM_EN = 1'b1;
`else
  localparam logic LIM_EN = 1'b0;
`endif

  // Entry layout: rpm[29:16] speed[15:6] limiter[5] shift[4] mask[3:0]
  // mask bits: 3=rpm 2=speed 1=limiter 0=shift_event
  logic [29:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [29:0] e;
  string       nm;

  task automatic step(input logic t, input logic thr, input logic [1:0] g, input logic rs);
    bus.tick         = t;
    bus.throttle     = thr;
    bus.gear         = g;
    bus.reset_status = rs;
    @(posedge clk);
    #1;
    bus.tick         = 1'b0;
    bus.reset_status = 1'b0;
  endtask

  task automatic ticks(input int n, input logic thr, input logic [1:0] g);
    for (int i = 0; i < n; i++) step(1'b1, thr, g, 1'b0);
  endtask

  task automatic expect_vals(input string name, input logic [13:0] r, input logic [9:0] s,
                             input logic lim, input logic sh, input logic [3:0] m);
    exp_q.push_back({r, s, lim, sh, m});
    name_q.push_back(name);
  endtask

  // Monitor: outputs are always valid, so pending expectations are compared
  // on the falling edge following the clock edge that produced them.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e[3]) begin
          checks++;
          if (bus.rpm !== e[29:16]) begin
            errors++;
            $display("FAIL %s rpm got %0d want %0d", nm, bus.rpm, e[29:16]);
          end
        end
        if (e[2]) begin
          checks++;
          if (bus.speed !== e[15:6]) begin
            errors++;
            $display("FAIL %s speed got %0d want %0d", nm, bus.speed, e[15:6]);
          end
        end
        if (e[1]) begin
          checks++;
          if (bus.limiter !== e[5]) begin
            errors++;
            $display("FAIL %s limiter got %0b want %0b", nm, bus.limiter, e[5]);
          end
        end
        if (e[0]) begin
          checks++;
          if (bus.shift_event !== e[4]) begin
            errors++;
            $display("FAIL %s shift_event got %0b want %0b", nm, bus.shift_event, e[4]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b0;
    bus.tick         = 1'b0;
    bus.throttle     = 1'b0;
    bus.gear         = 2'd0;
    bus.reset_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_vals("reset_hold", 14'd1000, 10'd0, 1'b0, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b0, 2'd0, 1'b0);
    expect_vals("reset_idle", 14'd1000, 10'd0, 1'b0, 1'b0, 4'hF);

    ticks(10, 1'b1, 2'd0);
    expect_vals("accel10", 14'd5000, 10'd10, 1'b0, 1'b0, 4'hE);
    ticks(8, 1'b1, 2'd0);
    expect_vals("accel18", 14'd8000, 10'd18, LIM_EN, 1'b0, 4'hE);

`ifdef ENGINE_LIMITER_EN
    ticks(7, 1'b1, 2'd0);
    expect_vals("limit7", 14'd4500, 10'd25, 1'b1, 1'b0, 4'hE);
    ticks(1, 1'b1, 2'd0);
    expect_vals("limit_exit", 14'd4000, 10'd26, 1'b0, 1'b0, 4'hE);
    ticks(1, 1'b1, 2'd0);
    expect_vals("run_again", 14'd4400, 10'd27, 1'b0, 1'b0, 4'hE);
`else
    ticks(1, 1'b1, 2'd0);
    expect_vals("sat_run", 14'd8000, 10'd19, 1'b0, 1'b0, 4'hE);
    ticks(241, 1'b1, 2'd0);
    expect_vals("speed_250", 14'd8000, 10'd250, 1'b0, 1'b0, 4'hE);
    ticks(5, 1'b1, 2'd0);
    expect_vals("speed_hold", 14'd8000, 10'd250, 1'b0, 1'b0, 4'hE);
`endif

    step(1'b1, 1'b1, 2'd0, 1'b1);
    expect_vals("rst_status", 14'd1000, 10'd0, 1'b0, 1'b0, 4'hF);

    step(1'b0, 1'b0, 2'd1, 1'b1);
    expect_vals("rs_gear_load", 14'd1000, 10'd0, 1'b0, 1'b0, 4'hF);
    step(1'b1, 1'b1, 2'd1, 1'b0);
    expect_vals("g1_accel", 14'd1300, 10'd0, 1'b0, 1'b0, 4'h9);
    step(1'b1, 1'b0, 2'd1, 1'b0);
    expect_vals("decel1", 14'd1150, 10'd0, 1'b0, 1'b0, 4'h8);
    step(1'b1, 1'b0, 2'd1, 1'b0);
    expect_vals("decel2", 14'd1000, 10'd0, 1'b0, 1'b0, 4'h8);
    step(1'b1, 1'b0, 2'd1, 1'b0);
    expect_vals("decel_floor", 14'd1000, 10'd0, 1'b0, 1'b0, 4'h8);

    step(1'b0, 1'b0, 2'd0, 1'b1);
    expect_vals("rs2", 14'd1000, 10'd0, 1'b0, 1'b0, 4'hF);
    ticks(10, 1'b1, 2'd0);
    ticks(4, 1'b0, 2'd0);
    ticks(4, 1'b1, 2'd0);
    expect_vals("pre_shift", 14'd6000, 10'd18, 1'b0, 1'b0, 4'hF);
    step(1'b0, 1'b0, 2'd1, 1'b0);
    expect_vals("upshift", 14'd3000, 10'd18, 1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b0, 2'd1, 1'b0);
    expect_vals("pulse_end", 14'd3000, 10'd18, 1'b0, 1'b0, 4'hF);

    step(1'b0, 1'b0, 2'd0, 1'b1);
    ticks(10, 1'b1, 2'd0);
    expect_vals("g_5000", 14'd5000, 10'd10, 1'b0, 1'b0, 4'hC);
    step(1'b1, 1'b1, 2'd3, 1'b0);
    expect_vals("shift_over_tick", 14'd2000, 10'd11, 1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b0, 2'd3, 1'b0);
    expect_vals("g3_idle", 14'd2000, 10'd11, 1'b0, 1'b0, 4'hF);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    expect_vals("wrap_down", 14'd8000, 10'd11, LIM_EN, 1'b1, 4'hF);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    expect_vals("wrap_after", 14'd8000, 10'd11, LIM_EN, 1'b0, 4'hF);

    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_vals("async_rst", 14'd1000, 10'd0, 1'b0, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    rst = 1'b1;

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
